// File: rtl/tlb_fa.sv
`default_nettype none
// ============================================================================
//  Module   : tlb_fa
//  Brief    : Fully-associative Sv39 TLB. The lookup is registered and takes
//             one cycle. Refills come from the page-table walker, flushes are
//             SFENCE.VMA style, and the block reports hits to and takes
//             victims from a pseudo-LRU tracker.
//  Revision : 1.0  initial release
// ============================================================================
module tlb_fa #(
    parameter int ENTRIES = 8,
    parameter int ASID_W  = 16,
    parameter int PPN_W   = 44
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    // lookup
    input  logic                       lu_req_i,
    input  logic [26:0]                lu_vpn_i,
    input  logic [ASID_W-1:0]          lu_asid_i,
    output logic                       lu_valid_o,
    output logic                       lu_hit_o,
    output logic [PPN_W-1:0]           lu_ppn_o,
    output logic [7:0]                 lu_flags_o,
    // refill
    input  logic                       upd_valid_i,
    input  logic [26:0]                upd_vpn_i,
    input  logic [ASID_W-1:0]          upd_asid_i,
    input  logic [PPN_W-1:0]           upd_ppn_i,
    input  logic [7:0]                 upd_flags_i,
    input  logic [1:0]                 upd_size_i,
    // flush
    input  logic                       flush_i,
    input  logic [1:0]                 flush_mode_i,
    input  logic [ASID_W-1:0]          flush_asid_i,
    input  logic [26:0]                flush_vpn_i,
    // PLRU handshake
    output logic                       plru_hit_o,
    output logic [$clog2(ENTRIES)-1:0] plru_idx_o,
    input  logic [$clog2(ENTRIES)-1:0] plru_repl_idx_i
);

    localparam int c_IDX_W  = $clog2(ENTRIES);
    localparam int c_FLAG_G = 5;

    localparam logic [1:0] c_SZ_4K  = 2'd0;
    localparam logic [1:0] c_SZ_2M  = 2'd1;
    localparam logic [1:0] c_SZ_1G  = 2'd2;
    localparam logic [1:0] c_SZ_BAD = 2'd3;

    localparam logic [1:0] c_FL_ALL     = 2'd0;
    localparam logic [1:0] c_FL_ASID    = 2'd1;
    localparam logic [1:0] c_FL_VPN     = 2'd2;
    localparam logic [1:0] c_FL_VPNASID = 2'd3;

    // Entry storage; only the valid bits carry a reset
    logic [ENTRIES-1:0] r_valid;
    logic [26:0]        r_vpn   [ENTRIES];
    logic [ASID_W-1:0]  r_asid  [ENTRIES];
    logic [PPN_W-1:0]   r_ppn   [ENTRIES];
    logic [7:0]         r_flags [ENTRIES];
    logic [1:0]         r_size  [ENTRIES];

    // Response registers
    logic               r_lu_valid;
    logic               r_lu_hit;
    logic [PPN_W-1:0]   r_lu_ppn;
    logic [7:0]         r_lu_flags;
    logic [c_IDX_W-1:0] r_lu_idx;

    logic [ENTRIES-1:0] w_lu_match;
    logic [ENTRIES-1:0] w_upd_match;
    logic [ENTRIES-1:0] w_flush_clr;
    logic               w_lu_any;
    logic [c_IDX_W-1:0] w_lu_idx;
    logic [PPN_W-1:0]   w_lu_ppn;
    logic               w_upd_any;
    logic [c_IDX_W-1:0] w_upd_idx;
    logic               w_inv_any;
    logic [c_IDX_W-1:0] w_inv_idx;
    logic [c_IDX_W-1:0] w_victim;
    logic               w_upd_wr;

    // A page covers a VPN when vpn2 agrees, and vpn1/vpn0 as well for the
    // smaller page sizes.
    function automatic logic f_page_match(input logic [26:0] a,
                                          input logic [26:0] b,
                                          input logic [1:0]  sz);
        logic m;
        m = (a[26:18] == b[26:18]);
        if (sz == c_SZ_4K || sz == c_SZ_2M) m = m & (a[17:9] == b[17:9]);
        if (sz == c_SZ_4K)                  m = m & (a[8:0]  == b[8:0]);
        return m;
    endfunction

    // Per-entry comparators for lookup, refill and flush
    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
        logic w_glob;
        logic w_lu_asid_ok;
        logic w_upd_asid_ok;
        logic w_fl_asid_hit;
        logic w_fl_vpn_hit;

        assign w_glob        = r_flags[gi][c_FLAG_G];
        assign w_lu_asid_ok  = w_glob | (r_asid[gi] == lu_asid_i);
        assign w_upd_asid_ok = w_glob | (r_asid[gi] == upd_asid_i);
        assign w_fl_asid_hit = ~w_glob & (r_asid[gi] == flush_asid_i);
        assign w_fl_vpn_hit  = f_page_match(r_vpn[gi], flush_vpn_i, r_size[gi]);

        assign w_lu_match[gi]  = r_valid[gi] & w_lu_asid_ok
                               & f_page_match(r_vpn[gi], lu_vpn_i, r_size[gi]);
        // Refill hits an existing translation when it matches at the refill size
        assign w_upd_match[gi] = r_valid[gi] & w_upd_asid_ok
                               & f_page_match(r_vpn[gi], upd_vpn_i, upd_size_i);

        // Flush selection; a clear of an already-invalid entry is harmless
        always_comb begin
            w_flush_clr[gi] = 1'b0;
            case (flush_mode_i)
                c_FL_ALL:     w_flush_clr[gi] = 1'b1;
                c_FL_ASID:    w_flush_clr[gi] = w_fl_asid_hit;
                c_FL_VPN:     w_flush_clr[gi] = w_fl_vpn_hit;
                c_FL_VPNASID: w_flush_clr[gi] = w_fl_vpn_hit & w_fl_asid_hit;
                default:      w_flush_clr[gi] = 1'b0;
            endcase
        end
    end

    // Lowest-index priority encoders for lookup hit, refill hit and free slot
    always_comb begin
        w_lu_any  = |w_lu_match;
        w_upd_any = |w_upd_match;
        w_inv_any = ~&r_valid;
        w_lu_idx  = '0;
        w_upd_idx = '0;
        w_inv_idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (w_lu_match[i])  w_lu_idx  = c_IDX_W'(i);
            if (w_upd_match[i]) w_upd_idx = c_IDX_W'(i);
            if (!r_valid[i])    w_inv_idx = c_IDX_W'(i);
        end
    end

    // Superpages take their low PPN segments from the request VPN
    always_comb begin
        w_lu_ppn = r_ppn[w_lu_idx];
        case (r_size[w_lu_idx])
            c_SZ_2M: w_lu_ppn[8:0]  = lu_vpn_i[8:0];
            c_SZ_1G: w_lu_ppn[17:0] = lu_vpn_i[17:0];
            default: w_lu_ppn = r_ppn[w_lu_idx];
        endcase
    end

    // Victim: overwrite a matching entry, else the first free slot, else PLRU.
    // A flush in the same cycle wins and the refill is dropped.
    assign w_victim = w_upd_any ? w_upd_idx :
                      w_inv_any ? w_inv_idx : plru_repl_idx_i;
    assign w_upd_wr = upd_valid_i & ~flush_i & (upd_size_i != c_SZ_BAD);

    // Valid bits: flush clears, refill sets the victim
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_valid <= '0;
        end else if (flush_i) begin
            r_valid <= r_valid & ~w_flush_clr;
        end else if (w_upd_wr) begin
            r_valid[w_victim] <= 1'b1;
        end
    end

    // Entry payload written on refill; no reset needed behind the valid bit
    always_ff @(posedge clk_i) begin
        if (w_upd_wr) begin
            r_vpn[w_victim]   <= upd_vpn_i;
            r_asid[w_victim]  <= upd_asid_i;
            r_ppn[w_victim]   <= upd_ppn_i;
            r_flags[w_victim] <= upd_flags_i;
            r_size[w_victim]  <= upd_size_i;
        end
    end

    // Registered lookup response; payload is zero on a miss or idle cycle
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_lu_valid <= 1'b0;
            r_lu_hit   <= 1'b0;
            r_lu_ppn   <= '0;
            r_lu_flags <= '0;
            r_lu_idx   <= '0;
        end else begin
            r_lu_valid <= lu_req_i;
            r_lu_hit   <= lu_req_i & w_lu_any;
            r_lu_ppn   <= (lu_req_i & w_lu_any) ? w_lu_ppn          : '0;
            r_lu_flags <= (lu_req_i & w_lu_any) ? r_flags[w_lu_idx] : '0;
            r_lu_idx   <= (lu_req_i & w_lu_any) ? w_lu_idx          : '0;
        end
    end

    assign lu_valid_o = r_lu_valid;
    assign lu_hit_o   = r_lu_hit;
    assign lu_ppn_o   = r_lu_ppn;
    assign lu_flags_o = r_lu_flags;
    assign plru_hit_o = r_lu_valid & r_lu_hit;
    assign plru_idx_o = r_lu_idx;

endmodule
`default_nettype wire

// File: tb/tb_tlb_fa.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tlb_fa
//  Brief    : Self-checking bench for tlb_fa: directed vector table, reset
//             sequences and random traffic against a behavioural model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_tlb_fa;

    localparam int ENTRIES = 8;
    localparam int ASID_W  = 16;
    localparam int PPN_W   = 44;
    localparam int IW      = 3;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              lu_req_i;
    logic [26:0]       lu_vpn_i;
    logic [ASID_W-1:0] lu_asid_i;
    logic              lu_valid_o;
    logic              lu_hit_o;
    logic [PPN_W-1:0]  lu_ppn_o;
    logic [7:0]        lu_flags_o;
    logic              upd_valid_i;
    logic [26:0]       upd_vpn_i;
    logic [ASID_W-1:0] upd_asid_i;
    logic [PPN_W-1:0]  upd_ppn_i;
    logic [7:0]        upd_flags_i;
    logic [1:0]        upd_size_i;
    logic              flush_i;
    logic [1:0]        flush_mode_i;
    logic [ASID_W-1:0] flush_asid_i;
    logic [26:0]       flush_vpn_i;
    logic              plru_hit_o;
    logic [IW-1:0]     plru_idx_o;
    logic [IW-1:0]     plru_repl_idx_i;

    tlb_fa #(.ENTRIES(ENTRIES), .ASID_W(ASID_W), .PPN_W(PPN_W)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .lu_req_i(lu_req_i), .lu_vpn_i(lu_vpn_i), .lu_asid_i(lu_asid_i),
        .lu_valid_o(lu_valid_o), .lu_hit_o(lu_hit_o), .lu_ppn_o(lu_ppn_o),
        .lu_flags_o(lu_flags_o),
        .upd_valid_i(upd_valid_i), .upd_vpn_i(upd_vpn_i), .upd_asid_i(upd_asid_i),
        .upd_ppn_i(upd_ppn_i), .upd_flags_i(upd_flags_i), .upd_size_i(upd_size_i),
        .flush_i(flush_i), .flush_mode_i(flush_mode_i), .flush_asid_i(flush_asid_i),
        .flush_vpn_i(flush_vpn_i),
        .plru_hit_o(plru_hit_o), .plru_idx_o(plru_idx_o),
        .plru_repl_idx_i(plru_repl_idx_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        req;   logic [26:0] vpn;   logic [15:0] asid;
        logic        upd;   logic [26:0] uvpn;  logic [15:0] uasid;
        logic [43:0] uppn;  logic [7:0]  uflg;  logic [1:0]  usz;
        logic        flush; logic [1:0]  fmode; logic [15:0] fasid;
        logic [26:0] fvpn;  logic [2:0]  repl;
        logic        ehit;  logic [43:0] eppn;  logic [7:0]  eflg;
        logic [2:0]  eidx;
    } vec_t;

    typedef struct {
        bit v; bit [26:0] vpn; bit [15:0] asid; bit [43:0] ppn; bit [7:0] fl; int sz;
    } ent_t;

    ent_t mdl[ENTRIES];
    int   total = 0;
    int   bad   = 0;

    // ---------------- behavioural reference model ----------------
    function automatic bit same_page(bit [26:0] a, bit [26:0] b, int sz);
        return (a >> (9 * sz)) == (b >> (9 * sz));
    endfunction

    task automatic mdl_reset();
        for (int i = 0; i < ENTRIES; i++) mdl[i].v = 1'b0;
    endtask

    task automatic mdl_lookup(input bit [26:0] vpn, input bit [15:0] asid,
                              output bit hit, output bit [43:0] ppn,
                              output bit [7:0] fl, output int idx);
        bit [63:0] mask;
        bit [63:0] p64;
        hit = 0; ppn = '0; fl = '0; idx = 0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (!hit && mdl[i].v && same_page(mdl[i].vpn, vpn, mdl[i].sz) &&
                (mdl[i].fl[5] || mdl[i].asid == asid)) begin
                mask = (64'd1 << (9 * mdl[i].sz)) - 64'd1;
                p64  = (64'(mdl[i].ppn) & ~mask) | (64'(vpn) & mask);
                hit  = 1; idx = i; fl = mdl[i].fl; ppn = p64[43:0];
            end
        end
    endtask

    task automatic mdl_update(input vec_t t);
        bit ah, vh, clr;
        int victim;
        if (t.flush) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ah = !mdl[i].fl[5] && mdl[i].asid == t.fasid;
                vh = same_page(mdl[i].vpn, t.fvpn, mdl[i].sz);
                case (t.fmode)
                    2'd0:    clr = 1;
                    2'd1:    clr = ah;
                    2'd2:    clr = vh;
                    default: clr = ah && vh;
                endcase
                if (clr) mdl[i].v = 0;
            end
        end else if (t.upd && t.usz != 2'd3) begin
            victim = -1;
            for (int i = 0; i < ENTRIES; i++)
                if (victim < 0 && mdl[i].v && same_page(mdl[i].vpn, t.uvpn, int'(t.usz)) &&
                    (mdl[i].fl[5] || mdl[i].asid == t.uasid)) victim = i;
            for (int i = 0; i < ENTRIES; i++)
                if (victim < 0 && !mdl[i].v) victim = i;
            if (victim < 0) victim = int'(t.repl);
            mdl[victim] = '{1'b1, t.uvpn, t.uasid, t.uppn, t.uflg, int'(t.usz)};
        end
    endtask

    // ---------------- stimulus helpers ----------------
    function automatic vec_t z();
        vec_t t;
        t = '{default: '0};
        return t;
    endfunction

    function automatic vec_t lk(logic [26:0] vpn, logic [15:0] asid, logic hit,
                                logic [43:0] ppn, logic [7:0] fl, logic [2:0] idx);
        vec_t t = z();
        t.req = 1; t.vpn = vpn; t.asid = asid;
        t.ehit = hit; t.eppn = ppn; t.eflg = fl; t.eidx = idx;
        return t;
    endfunction

    function automatic vec_t rf(logic [26:0] vpn, logic [15:0] asid, logic [43:0] ppn,
                                logic [7:0] fl, logic [1:0] sz, logic [2:0] repl);
        vec_t t = z();
        t.upd = 1; t.uvpn = vpn; t.uasid = asid; t.uppn = ppn; t.uflg = fl;
        t.usz = sz; t.repl = repl;
        return t;
    endfunction

    function automatic vec_t fls(logic [1:0] mode, logic [15:0] asid, logic [26:0] vpn);
        vec_t t = z();
        t.flush = 1; t.fmode = mode; t.fasid = asid; t.fvpn = vpn;
        return t;
    endfunction

    task automatic check(string tag, string nm, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s %s: got %0h expected %0h", tag, nm, act, exp);
        end
    endtask

    task automatic cmp(string tag, bit req, bit hit, bit [43:0] ppn, bit [7:0] fl, int idx);
        check(tag, "lu_valid", 64'(lu_valid_o), 64'(req));
        check(tag, "lu_hit",   64'(lu_hit_o),   64'(req && hit));
        check(tag, "lu_ppn",   64'(lu_ppn_o),   64'(ppn));
        check(tag, "lu_flags", 64'(lu_flags_o), 64'(fl));
        check(tag, "plru_hit", 64'(plru_hit_o), 64'(req && hit));
        if (req && hit) check(tag, "plru_idx", 64'(plru_idx_o), 64'(idx));
    endtask

    // Drive one cycle; returns the model's view of this cycle's lookup
    task automatic run(input vec_t t, output bit mh, output bit [43:0] mp,
                       output bit [7:0] mf, output int mi);
        lu_req_i = t.req; lu_vpn_i = t.vpn; lu_asid_i = t.asid;
        upd_valid_i = t.upd; upd_vpn_i = t.uvpn; upd_asid_i = t.uasid;
        upd_ppn_i = t.uppn; upd_flags_i = t.uflg; upd_size_i = t.usz;
        flush_i = t.flush; flush_mode_i = t.fmode; flush_asid_i = t.fasid;
        flush_vpn_i = t.fvpn; plru_repl_idx_i = t.repl;
        mdl_lookup(t.vpn, t.asid, mh, mp, mf, mi);
        if (!t.req) begin mh = 0; mp = '0; mf = '0; mi = 0; end
        @(posedge clk_i);
        mdl_update(t);
        #1;
    endtask

    localparam logic [7:0] F  = 8'hC3;
    localparam logic [7:0] FG = 8'hE3;

    vec_t tbl[$];

    initial begin
        vec_t      t;
        bit        mh;
        bit [43:0] mp;
        bit [7:0]  mf;
        int        mi;
        logic [7:0] rfl;

        // ---- reset ----
        rst_i = 1;
        t = z();
        lu_req_i = 0; lu_vpn_i = '0; lu_asid_i = '0;
        upd_valid_i = 0; upd_vpn_i = '0; upd_asid_i = '0; upd_ppn_i = '0;
        upd_flags_i = '0; upd_size_i = '0; flush_i = 0; flush_mode_i = '0;
        flush_asid_i = '0; flush_vpn_i = '0; plru_repl_idx_i = '0;
        mdl_reset();
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 0;
        check("reset", "lu_valid",  64'(lu_valid_o), 64'd0);
        check("reset", "lu_hit",    64'(lu_hit_o),   64'd0);
        check("reset", "lu_ppn",    64'(lu_ppn_o),   64'd0);
        check("reset", "lu_flags",  64'(lu_flags_o), 64'd0);
        check("reset", "plru_hit",  64'(plru_hit_o), 64'd0);
        check("reset", "plru_idx",  64'(plru_idx_o), 64'd0);

        // ---- directed vector table ----
        tbl.push_back(lk(27'h0001234, 5, 0, 0, 0, 0));
        for (int i = 0; i < 8; i++) tbl.push_back(rf(27'(i), 1, 44'(32'h100 + i), F, 0, 0));
        tbl.push_back(lk(3, 1, 1, 44'h103, F, 3));
        tbl.push_back(rf(27'h40, 1, 44'h200, F, 0, 6));
        tbl.push_back(lk(6, 1, 0, 0, 0, 0));
        tbl.push_back(lk(27'h40, 1, 1, 44'h200, F, 6));
        tbl.push_back(rf(27'h40000, 3, 44'h40000, FG, 2, 2));
        tbl.push_back(lk(27'h556CD, 9, 1, 44'h556CD, FG, 2));
        tbl.push_back(rf(27'h55, 2, 44'h300, F, 0, 5));
        tbl.push_back(fls(1, 1, 0));
        tbl.push_back(lk(3, 1, 0, 0, 0, 0));
        tbl.push_back(lk(27'h55, 2, 1, 44'h300, F, 5));
        tbl.push_back(lk(27'h556CD, 1, 1, 44'h556CD, FG, 2));
        tbl.push_back(lk(27'h40, 1, 0, 0, 0, 0));
        t = fls(2, 0, 27'h999);
        t.upd = 1; t.uvpn = 7; t.uasid = 1; t.uppn = 44'h777; t.uflg = F; t.usz = 0;
        tbl.push_back(t);
        tbl.push_back(lk(7, 1, 0, 0, 0, 0));
        tbl.push_back(rf(27'h55, 2, 44'h301, F, 0, 0));
        tbl.push_back(lk(27'h55, 2, 1, 44'h301, F, 5));
        t = lk(27'h88, 4, 0, 0, 0, 0);
        t.upd = 1; t.uvpn = 27'h88; t.uasid = 4; t.uppn = 44'h888; t.uflg = F; t.usz = 0;
        tbl.push_back(t);
        tbl.push_back(lk(27'h88, 4, 1, 44'h888, F, 0));
        tbl.push_back(lk(27'h88, 4, 1, 44'h888, F, 0));
        t = lk(27'h88, 4, 1, 44'h888, F, 0);
        t.flush = 1; t.fmode = 0;
        tbl.push_back(t);
        tbl.push_back(lk(27'h88, 4, 0, 0, 0, 0));
        tbl.push_back(rf(27'hA00, 7, 44'hABC00, F, 1, 0));
        tbl.push_back(lk(27'hBFF, 7, 1, 44'hABDFF, F, 0));
        tbl.push_back(lk(27'hBFF, 8, 0, 0, 0, 0));
        tbl.push_back(rf(27'h99, 7, 44'h5, F, 3, 0));
        tbl.push_back(lk(27'h99, 7, 0, 0, 0, 0));
        tbl.push_back(rf(27'h99, 7, 44'h5, F, 0, 0));
        tbl.push_back(fls(3, 8, 27'h99));
        tbl.push_back(lk(27'h99, 7, 1, 44'h5, F, 1));
        tbl.push_back(fls(3, 7, 27'h99));
        tbl.push_back(lk(27'h99, 7, 0, 0, 0, 0));
        tbl.push_back(lk(27'hA00, 7, 1, 44'hABC00, F, 0));

        foreach (tbl[k]) begin
            run(tbl[k], mh, mp, mf, mi);
            cmp($sformatf("vec%0d", k), tbl[k].req, tbl[k].ehit, tbl[k].eppn, tbl[k].eflg,
                int'(tbl[k].eidx));
        end

        // ---- reset while a response is on the outputs ----
        run(lk(27'hA00, 7, 1, 44'hABC00, F, 0), mh, mp, mf, mi);
        cmp("prerst", 1, 1, 44'hABC00, F, 0);
        #2 rst_i = 1;
        #1;
        mdl_reset();
        cmp("inrst", 0, 0, 0, 0, 0);
        @(posedge clk_i);
        #1;
        lu_req_i = 0;
        rst_i = 0;
        @(posedge clk_i);
        #1;
        check("postrst", "lu_valid", 64'(lu_valid_o), 64'd0);
        run(lk(27'hA00, 7, 0, 0, 0, 0), mh, mp, mf, mi);
        cmp("rstmiss0", 1, 0, 0, 0, 0);
        run(lk(27'hBFF, 7, 0, 0, 0, 0), mh, mp, mf, mi);
        cmp("rstmiss1", 1, 0, 0, 0, 0);

        // ---- random traffic against the model ----
        for (int n = 0; n < 600; n++) begin
            t = z();
            t.req  = ($urandom_range(0, 3) != 0);
            t.vpn  = {9'($urandom_range(0, 2)), 9'($urandom_range(0, 2)), 9'($urandom_range(0, 3))};
            t.asid = 16'($urandom_range(0, 2));
            t.upd  = ($urandom_range(0, 2) == 0);
            t.uvpn = {9'($urandom_range(0, 2)), 9'($urandom_range(0, 2)), 9'($urandom_range(0, 3))};
            t.uasid = 16'($urandom_range(0, 2));
            t.uppn = {12'($urandom), 32'($urandom)};
            rfl    = 8'($urandom) & 8'hDF;
            if ($urandom_range(0, 4) == 0) rfl = rfl | 8'h20;
            t.uflg = rfl | 8'h01;
            t.usz  = 2'($urandom_range(0, 3));
            t.flush = ($urandom_range(0, 11) == 0);
            t.fmode = 2'($urandom_range(0, 3));
            t.fasid = 16'($urandom_range(0, 2));
            t.fvpn = {9'($urandom_range(0, 2)), 9'($urandom_range(0, 2)), 9'($urandom_range(0, 3))};
            t.repl = 3'($urandom_range(0, 7));
            run(t, mh, mp, mf, mi);
            cmp($sformatf("rnd%0d", n), t.req, mh, mp, mf, mi);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
